// File: rtl/hpm_counter_file.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// hpm_counter_file
//
// Hardware performance-monitor CSR bank. Provides mhpmcounter3.., their high
// halves, the user read-only shadows (hpmcounter / hpmcounterh) and the
// matching mhpmevent selectors. Counters advance on core-supplied event
// strobes. Each counter has a sticky overflow flag, and those flags drive an
// interrupt request.
//
// Ports
//   CLK          : clock, all state updates on the rising edge
//   RESET        : asynchronous, active-high reset
//   WR_EN        : CSR write strobe for the current CSR_ADDR
//   CSR_ADDR     : 12-bit CSR address
//   CSR_OP       : [2] immediate source select, [1:0] 00 NOP / 01 RW / 10 RS / 11 RC
//   CSR_UIMM     : 5-bit immediate operand
//   CSR_DATA_IN  : 32-bit register operand
//   CSR_DATA_OUT : combinational read data, 0 when the address is not owned
//   ADDR_HIT     : combinational, 1 when CSR_ADDR belongs to this bank
//   EVENTS       : per-cycle event strobes, registered once before counting
//   OVF_IRQ      : OR of all overflow (OF) flags
//
// mhpmevent layout: [7:0] SEL, [29:8] zero, [30] INH, [31] OF.
// ---------------------------------------------------------------------------
module hpm_counter_file #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WR_EN,
    input  logic [11:0]           CSR_ADDR,
    input  logic [2:0]            CSR_OP,
    input  logic [4:0]            CSR_UIMM,
    input  logic [31:0]           CSR_DATA_IN,
    output logic [31:0]           CSR_DATA_OUT,
    output logic                  ADDR_HIT,
    input  logic [NUM_EVENTS-1:0] EVENTS,
    output logic                  OVF_IRQ
);

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    localparam logic [11:0] BASE_MCNT_LO = 12'hB03;
    localparam logic [11:0] BASE_MCNT_HI = 12'hB83;
    localparam logic [11:0] BASE_UCNT_LO = 12'hC03;
    localparam logic [11:0] BASE_UCNT_HI = 12'hC83;
    localparam logic [11:0] BASE_EVT     = 12'h323;

    // -----------------------------------------------------------------------
    // Write data: derived from the current read value so that RS/RC act on
    // exactly what software would observe.
    // -----------------------------------------------------------------------
    logic [31:0] src_data;
    logic [31:0] wdata;

    always_comb begin
        src_data = CSR_OP[2] ? {27'b0, CSR_UIMM} : CSR_DATA_IN;
        case (CSR_OP[1:0])
            OP_RW:   wdata = src_data;
            OP_RS:   wdata = CSR_DATA_OUT | src_data;
            OP_RC:   wdata = CSR_DATA_OUT & ~src_data;
            OP_NOP:  wdata = CSR_DATA_OUT;
            default: wdata = CSR_DATA_OUT;
        endcase
    end

    // -----------------------------------------------------------------------
    // Event sampling. The registered strobes are re-packed so that index 0 is
    // a permanent zero: SEL = 0 and SEL > NUM_EVENTS then select a 0 bit with
    // no extra range comparison.
    // -----------------------------------------------------------------------
    logic [NUM_EVENTS-1:0] event_q;
    logic [NUM_EVENTS-1:0] event_d;
    logic [255:0]          event_ext;

    always_comb begin
        event_d = EVENTS;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            event_q <= '0;
        end else begin
            event_q <= event_d;
        end
    end

    always_comb begin
        event_ext                = '0;
        event_ext[NUM_EVENTS:1]  = event_q;
    end

    // -----------------------------------------------------------------------
    // Per-counter slices
    // -----------------------------------------------------------------------
    logic [NUM_COUNTERS-1:0][31:0] rd_data_vec;
    logic [NUM_COUNTERS-1:0]       hit_vec;
    logic [NUM_COUNTERS-1:0]       of_vec;

    generate
        for (genvar gi = 0; gi < NUM_COUNTERS; gi++) begin : g_ctr
            localparam logic [11:0] ADDR_MLO = BASE_MCNT_LO + 12'(gi);
            localparam logic [11:0] ADDR_MHI = BASE_MCNT_HI + 12'(gi);
            localparam logic [11:0] ADDR_ULO = BASE_UCNT_LO + 12'(gi);
            localparam logic [11:0] ADDR_UHI = BASE_UCNT_HI + 12'(gi);
            localparam logic [11:0] ADDR_EVT = BASE_EVT     + 12'(gi);

            logic [COUNTER_WIDTH-1:0] cnt_q;
            logic [COUNTER_WIDTH-1:0] cnt_d;
            logic [7:0]               sel_q;
            logic [7:0]               sel_d;
            logic                     inh_q;
            logic                     inh_d;
            logic                     of_q;
            logic                     of_d;

            logic hit_mlo;
            logic hit_mhi;
            logic hit_ulo;
            logic hit_uhi;
            logic hit_evt;
            logic wr_lo;
            logic wr_hi;
            logic wr_evt;
            logic inc_en;
            logic wrap;
            logic [31:0] rd_word;

            assign hit_mlo = (CSR_ADDR == ADDR_MLO);
            assign hit_mhi = (CSR_ADDR == ADDR_MHI);
            assign hit_ulo = (CSR_ADDR == ADDR_ULO);
            assign hit_uhi = (CSR_ADDR == ADDR_UHI);
            assign hit_evt = (CSR_ADDR == ADDR_EVT);

            // User shadows are never writable, so only machine addresses
            // produce write enables.
            assign wr_lo  = WR_EN & hit_mlo;
            assign wr_hi  = WR_EN & hit_mhi;
            assign wr_evt = WR_EN & hit_evt;

            assign inc_en = ~inh_q & event_ext[sel_q];
            assign wrap   = (cnt_q == '1);

            always_comb begin
                rd_word = '0;
                if (hit_mlo | hit_ulo) begin
                    rd_word = cnt_q[31:0];
                end
                if (hit_mhi | hit_uhi) begin
                    rd_word = 32'(cnt_q >> 32);
                end
                if (hit_evt) begin
                    rd_word = {of_q, inh_q, 22'b0, sel_q};
                end
            end

            // A software write to either half takes priority over the
            // increment, and also suppresses any overflow from that increment.
            always_comb begin
                cnt_d = cnt_q;
                if (wr_lo) begin
                    cnt_d = {cnt_q[COUNTER_WIDTH-1:32], wdata};
                end else if (wr_hi) begin
                    cnt_d = COUNTER_WIDTH'({wdata, cnt_q[31:0]});
                end else if (inc_en) begin
                    cnt_d = cnt_q + COUNTER_WIDTH'(1);
                end
            end

            // A hardware overflow always survives a same-cycle event write.
            always_comb begin
                logic of_set;
                of_set = inc_en & wrap & ~wr_lo & ~wr_hi;
                sel_d  = sel_q;
                inh_d  = inh_q;
                of_d   = of_q | of_set;
                if (wr_evt) begin
                    sel_d = wdata[7:0];
                    inh_d = wdata[30];
                    of_d  = wdata[31] | of_set;
                end
            end

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    cnt_q <= '0;
                    sel_q <= '0;
                    inh_q <= 1'b0;
                    of_q  <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    sel_q <= sel_d;
                    inh_q <= inh_d;
                    of_q  <= of_d;
                end
            end

            assign rd_data_vec[gi] = rd_word;
            assign hit_vec[gi]     = hit_mlo | hit_mhi | hit_ulo | hit_uhi | hit_evt;
            assign of_vec[gi]      = of_q;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read mux: at most one slice claims an address, so OR-combining is exact.
    // -----------------------------------------------------------------------
    always_comb begin
        CSR_DATA_OUT = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            CSR_DATA_OUT = CSR_DATA_OUT | rd_data_vec[i];
        end
    end

    assign ADDR_HIT = |hit_vec;
    assign OVF_IRQ  = |of_vec;

endmodule

// File: doc/hpm_counter_file.md
# hpm_counter_file

Parametrised hardware performance-monitor CSR bank for the Steel Core, providing `mhpmcounter3..(3+NUM_COUNTERS-1)`, their `h` halves and user read-only shadows, and the matching `mhpmevent` selectors. It sits beside the machine CSR file on the same CSR access bus (address, op, uimm, data) and counts core-supplied event strobes. It adds features the fixed counters do not have:

- configurable counter count and width;
- per-counter event selection and inhibit;
- sticky overflow flags driving an overflow interrupt request to the interrupt controller.

## Interface

Parameters:
- NUM_COUNTERS, default 4, number of HPM counters, legal 1..29; counter i maps to index 3+i.
- COUNTER_WIDTH, default 64, counter width in bits, legal 33..64.
- NUM_EVENTS, default 8, number of event strobe inputs, legal 1..255.

Ports:
- CLK, input, 1, clock; all state updates on the rising edge.
- RESET, input, 1, asynchronous, active-high.
- WR_EN, input, 1, CSR write strobe for the current CSR_ADDR.
- CSR_ADDR, input, 12, CSR address.
- CSR_OP, input, 3, CSR operation:
  - bit2 = 1: source is {27'b0, CSR_UIMM};
  - bit2 = 0: source is CSR_DATA_IN;
  - [1:0]: 00 NOP, 01 RW, 10 RS, 11 RC.
- CSR_UIMM, input, 5, immediate operand.
- CSR_DATA_IN, input, 32, register operand.
- CSR_DATA_OUT, output, 32, combinational read data; 0 if the address is not owned.
- ADDR_HIT, output, 1, combinational; 1 when CSR_ADDR is owned by this block.
- EVENTS, input, NUM_EVENTS, per-cycle event strobes, level-sampled.
- OVF_IRQ, output, 1, OR of all OF flags.

## Operation

Address map, for i = 0..NUM_COUNTERS-1:
- mhpmcounter: 0xB03+i, read/write.
- mhpmcounterh: 0xB83+i, read/write.
- hpmcounter: 0xC03+i, read-only.
- hpmcounterh: 0xC83+i, read-only.
- mhpmevent: 0x323+i, read/write.
- Addresses beyond NUM_COUNTERS are not owned.

Write semantics:
- Write data is computed from the current CSR_DATA_OUT:
  - RW: source;
  - RS: out | source;
  - RC: out & ~source;
  - NOP: out.
- A write commits only when WR_EN = 1 and the address is owned and writable.
- Writes to 0xC03..0xC9F are ignored silently.

Counter halves:
- Low half: counter bits [31:0].
- High half: bits [COUNTER_WIDTH-1:32], zero-extended on read.
- Bits written above COUNTER_WIDTH are dropped.

mhpmevent layout:
- [7:0] SEL;
- [29:8] read as 0, writes ignored;
- [30] INH;
- [31] OF.

Counting:
- EVENTS is registered once into an internal event_q.
- Counter i increments by 1 on an edge where INH = 0, 1 ≤ SEL ≤ NUM_EVENTS and event_q[SEL-1] = 1.
- SEL = 0 or SEL > NUM_EVENTS never counts.

Overflow:
- Incrementing from all-ones wraps the counter to 0 and sets OF.
- OF is sticky; only a software write clears it.

Simultaneous events:
- Counter write (either half) and increment in the same cycle: the write wins, with no increment and no OF set. The untouched half keeps its value.
- mhpmevent write and hardware OF set in the same cycle: OF becomes the written bit31 OR 1 (set wins). SEL and INH take the written values.
- Setting INH stops counting from the next edge. An event already in event_q is dropped if INH = 1 at the counting edge.

Reset (asynchronous):
- Counters, mhpmevent registers and event_q go to 0.
- OVF_IRQ = 0 and CSR_DATA_OUT reflects the zero state.
- A reset mid-count discards all state immediately.

## Timing

- CSR_DATA_OUT and ADDR_HIT are combinational from CSR_ADDR; there is no read latency.
- A write at edge k is visible on CSR_DATA_OUT after edge k. The same-cycle read returns the old value.
- Event latency:
  - EVENTS high in the cycle before edge k is sampled at edge k;
  - the counter increments at edge k+1;
  - the new value is readable in the cycle after edge k+1.
- OVF_IRQ rises in the cycle after the wrapping edge. It falls in the cycle after the edge where software clears the last OF.
- One-cycle EVENTS pulses each count once. A level held for N cycles counts N.

## Test plan

- Reset: assert RESET mid-operation → all counters and mhpmevent read 0, OVF_IRQ = 0, ADDR_HIT = 1 at 0xB03 and 0 at 0xB03+NUM_COUNTERS.
- Count: write 0x323 = 0x00000002, hold EVENTS[1] high for 10 cycles → 0xB03 reads 10 and starts incrementing exactly 2 edges after the first high sample; 0xC03 returns the same value.
- Overflow: write 0xB83 = 0xFFFFFFFF, 0xB03 = 0xFFFFFFFE, SEL = 1, EVENTS[0] high for 2 cycles → counter = 0, OF = 1, OVF_IRQ = 1. Then RC 0x323 with 0x80000000 → OVF_IRQ = 0 next cycle.
- Collision: with counting active, RW 0xB03 = 0x100 → reads 0x100 after the write edge and 0x101 one edge later. An event write that clears OF on the wrap edge leaves OF = 1.
- Ops and protection: RS with uimm 5 then RC with uimm 1 on 0x323 → 0x04. RW to 0xC03 leaves the counter unchanged. SEL = NUM_EVENTS+1 → no counting. INH = 1 → count frozen.
- Width: COUNTER_WIDTH = 40, write 0xB83 = 0xFFFFFFFF → reads 0x000000FF.
